hub75_line_scanner: RTL and testbench
=====================================

// Module: hub75_line_scanner
// PURPOSE
//  Reader/consumer end of the double-banked line buffer filled by the pixel generator.
//  Per panel row, fetches WIDTH 48-bit pixel pairs, bit-plane at a time (BCM), and shifts them to HUB-75 pins.
//  Also drives the generator handshake: start pulse, next row index y, bank-select counter frame_count.
// PARAMETERS
//  WIDTH        64  pixels per row; read_address[5:0] = x, 0..WIDTH-1
//  COLOR_BITS    8  bits per channel = bit planes per row
//  ROWS         32  panel scan rows; y and hub75_addr wrap ROWS-1 -> 0
//  ON_UNIT       1  OE-low cycles for plane 0; plane p gets ON_UNIT<<p
//  BLANK_CYCLES  2  ghost-blank length (only with HUB75_GHOST_BLANK_EN)
// PORTS
//  clock         in   1   system clock
//  reset         in   1   synchronous, active-high
//  gen_idle      in   1   generator is_idle
//  gen_start     out  1   one-cycle start pulse to generator
//  gen_y         out  5   row the generator must produce
//  frame_count   out  10  bank counter; generator writes bank frame_count[0]
//  read_address  out  7   {~frame_count[0], x[5:0]}; 1-cycle read latency
//  read_data     in   48  {R1,G1,B1,R2,G2,B2}, 8 bits each, [47:40]=R1
//  hub75_rgb     out  6   {R1,G1,B1,R2,G2,B2} bit of current plane
//  hub75_clk     out  1   shift clock; panel samples on rising edge
//  hub75_lat     out  1   latch strobe
//  hub75_oe_n    out  1   output enable, active low
//  hub75_addr    out  5   displayed row
// BEHAVIOUR
//  Reset: all outputs 0 except hub75_oe_n=1; frame_count=0, gen_y=0, plane=0; state PRIME.
//   Sync reset mid-row aborts at once; pins return to reset values on the next edge.
//  All outputs registered. States:
//  PRIME    1 cycle: gen_start=1 (gen_y=0) -> WAIT_GEN.
//  WAIT_GEN oe_n=1; ignore gen_idle in the first cycle after a gen_start. Then, on gen_idle=1:
//           frame_count+=1 (10-bit wrap), row_disp<=gen_y, gen_y<=gen_y+1 (mod ROWS),
//           gen_start=1, plane=0 -> PREFETCH.
//  PREFETCH 1 cycle: read_address x=0, hub75_clk=0 -> SHIFT.
//  SHIFT    2 cycles per pixel, x=0..WIDTH-1.
//           Cycle A: hub75_rgb <= read_data bit [plane] of each 8-bit field; hub75_clk=0;
//                    read_address x+1 (unchanged at x=WIDTH-1).
//           Cycle B: hub75_clk=1, rgb held.
//           After last B -> LATCH.
//  LATCH    1 cycle: hub75_lat=1, oe_n=1, hub75_addr<=row_disp -> DISPLAY.
//  DISPLAY  oe_n=0 for ON_UNIT<<plane cycles.
//           Then, if plane<COLOR_BITS-1: plane+=1 -> PREFETCH; else oe_n=1 -> WAIT_GEN.
//  Plane cycles = 2*WIDTH+2+(ON_UNIT<<plane).
//  frame_count/bank stable for the entire generator run; scanner only reads ~frame_count[0].
//  Generator late (gen_idle=0 at row end): stay in WAIT_GEN, panel blanked (oe_n=1), no reads.
//  Row ROWS-1 followed by row 0; gen_start asserted only in PRIME and on a WAIT_GEN exit.
// CONFIGURATION
//  HUB75_GHOST_BLANK_EN defined:
//   BLANK state inserted between LATCH and DISPLAY; oe_n=1, lat=0 for BLANK_CYCLES.
//   Suppresses ghosting on row-address change.
//  Undefined: LATCH goes directly to DISPLAY; BLANK_CYCLES unused.
// TESTING (WIDTH=4, COLOR_BITS=2, ON_UNIT=2, model gen: idle 5 cycles after start, RAM 1-cycle latency)
//  Reset -> oe_n=1, lat=clk=0, frame_count=0.
//   Cycle after release: gen_start=1 with gen_y=0.
//  Bank 1 x0..3 = 48'hFF0000_000000, 0, 48'h0100FF_000000, 0:
//   plane 0 rising clk rgb = 100000, 000000, 101000, 000000;
//   plane 1 = 100000, 000000, 001000, 000000.
//  Timing: plane 0 oe_n low exactly 2 cycles; plane 1 exactly 4.
//   lat single-cycle pulse after 4th clk rise; hub75_addr=0 at first lat.
//  Hold gen_idle=0 for 50 cycles at row end: oe_n=1 throughout, no clk pulses.
//   Resume: frame_count+1, gen_start, gen_y+1.
//  Run 33 rows: hub75_addr 0..31 then 0.
//   gen_y wraps 31->0; frame_count[0] toggles each row; read bank always != write bank.
//  Assert reset during SHIFT: next cycle outputs at reset values; PRIME restarts with gen_y=0.
//  With HUB75_GHOST_BLANK_EN: exactly 2 oe_n=1 cycles between lat and first oe_n=0 cycle.

Source files
------------

// File: rtl/hub75_line_scanner_if.sv
// Bundle of the scanner's generator handshake, line-buffer read port and
// HUB-75 panel pins. The scanner takes the master side; the generator,
// line-buffer RAM and panel take the slave side.
interface hub75_line_scanner_if;
   logic        gen_idle;
   logic        gen_start;
   logic [4:0]  gen_y;
   logic [9:0]  frame_count;
   logic [6:0]  read_address;
   logic [47:0] read_data;
   logic [5:0]  hub75_rgb;
   logic        hub75_clk;
   logic        hub75_lat;
   logic        hub75_oe_n;
   logic [4:0]  hub75_addr;

   modport master (
      input  gen_idle, read_data,
      output gen_start, gen_y, frame_count, read_address,
             hub75_rgb, hub75_clk, hub75_lat, hub75_oe_n, hub75_addr
   );

   modport slave (
      output gen_idle, read_data,
      input  gen_start, gen_y, frame_count, read_address,
             hub75_rgb, hub75_clk, hub75_lat, hub75_oe_n, hub75_addr
   );
endinterface

// File: rtl/hub75_line_scanner.sv
// HUB-75 line scanner: consumer end of the double-banked line buffer.
// For each panel row it shifts WIDTH pixel pairs out once per bit plane
// (binary-coded modulation), latches them, and lights the row for
// ON_UNIT<<plane cycles. It also kicks the pixel generator for the next row
// and flips the bank counter so generator and scanner never share a bank.
// Optional feature: define HUB75_GHOST_BLANK_EN to insert BLANK_CYCLES
// blanked cycles between the latch strobe and the lit period.
// Every pin and handshake output comes straight from a register.
module hub75_line_scanner #(
   parameter int WIDTH        = 64,
   parameter int COLOR_BITS   = 8,
   parameter int ROWS         = 32,
   parameter int ON_UNIT      = 1,
   parameter int BLANK_CYCLES = 2
) (
   input  logic                 clock,
   input  logic                 reset,
   hub75_line_scanner_if.master bus
);

`ifdef HUB75_GHOST_BLANK_EN
   localparam bit GHOST_BLANK = 1'b1;
`else
   localparam bit GHOST_BLANK = 1'b0;
`endif

   localparam logic [5:0]  X_LAST     = 6'(WIDTH - 1);
   localparam logic [2:0]  PLANE_LAST = 3'(COLOR_BITS - 1);
   localparam logic [4:0]  ROW_LAST   = 5'(ROWS - 1);
   localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_PRIME,
      ST_WAIT_GEN,
      ST_PREFETCH,
      ST_SHIFT,
      ST_LATCH,
      ST_BLANK,
      ST_DISPLAY
   } state_t;

   state_t      state_reg, state_next;
   logic        gen_start_reg, gen_start_next;
   logic [4:0]  gen_y_reg, gen_y_next;
   logic [9:0]  frame_count_reg, frame_count_next;
   logic [6:0]  read_address_reg, read_address_next;
   logic [5:0]  rgb_reg, rgb_next;
   logic        hclk_reg, hclk_next;
   logic        lat_reg, lat_next;
   logic        oe_n_reg, oe_n_next;
   logic [4:0]  addr_reg, addr_next;
   logic [4:0]  row_disp_reg, row_disp_next;
   logic [2:0]  plane_reg, plane_next;
   logic [5:0]  x_reg, x_next;
   logic        phase_reg, phase_next;   // 0 = cycle A (load rgb), 1 = cycle B (clock high)
   logic [15:0] cnt_reg, cnt_next;       // shared by BLANK and DISPLAY timing

   logic [5:0]  plane_bits;
   logic [15:0] on_len;

   // Lit time doubles with each bit plane.
   assign on_len = 16'(ON_UNIT) << plane_reg;

   // Pick the current plane's bit from each of the six 8-bit colour fields;
   // field 0 is R1 in the top byte and lands on rgb[5].
   generate
      for (genvar gi = 0; gi < 6; gi++) begin : g_field
         logic [7:0] field;
         assign field             = bus.read_data[47 - 8*gi -: 8];
         assign plane_bits[5 - gi] = field[plane_reg];
      end
   endgenerate

   // Next-state and next-output logic for the row scan sequence.
   always_comb begin
      state_next        = state_reg;
      gen_start_next    = 1'b0;
      gen_y_next        = gen_y_reg;
      frame_count_next  = frame_count_reg;
      read_address_next = read_address_reg;
      rgb_next          = rgb_reg;
      hclk_next         = 1'b0;
      lat_next          = 1'b0;
      oe_n_next         = 1'b1;
      addr_next         = addr_reg;
      row_disp_next     = row_disp_reg;
      plane_next        = plane_reg;
      x_next            = x_reg;
      phase_next        = phase_reg;
      cnt_next          = cnt_reg;

      case (state_reg)
         ST_PRIME: begin
            gen_start_next = 1'b1;
            state_next     = ST_WAIT_GEN;
         end

         ST_WAIT_GEN: begin
            // gen_idle can still read as idle while our start pulse is out,
            // so it only counts once gen_start has dropped.
            if (!gen_start_reg && bus.gen_idle) begin
               frame_count_next  = frame_count_reg + 10'd1;
               row_disp_next     = gen_y_reg;
               gen_y_next        = (gen_y_reg == ROW_LAST) ? 5'd0 : gen_y_reg + 5'd1;
               gen_start_next    = 1'b1;
               plane_next        = 3'd0;
               x_next            = 6'd0;
               phase_next        = 1'b0;
               read_address_next = {~frame_count_next[0], 6'd0};
               state_next        = ST_PREFETCH;
            end
         end

         ST_PREFETCH: begin
            // Address x=0 is already out; this cycle covers the RAM latency.
            state_next = ST_SHIFT;
         end

         ST_SHIFT: begin
            if (!phase_reg) begin
               rgb_next   = plane_bits;
               phase_next = 1'b1;
               if (x_reg != X_LAST) begin
                  read_address_next = {read_address_reg[6], x_reg + 6'd1};
               end
            end else begin
               hclk_next  = 1'b1;
               phase_next = 1'b0;
               if (x_reg == X_LAST) begin
                  state_next = ST_LATCH;
               end else begin
                  x_next = x_reg + 6'd1;
               end
            end
         end

         ST_LATCH: begin
            lat_next   = 1'b1;
            addr_next  = row_disp_reg;
            cnt_next   = 16'd0;
            state_next = (GHOST_BLANK && BLANK_CYCLES > 0) ? ST_BLANK : ST_DISPLAY;
         end

         ST_BLANK: begin
            if (cnt_reg == BLANK_LAST) begin
               cnt_next   = 16'd0;
               state_next = ST_DISPLAY;
            end else begin
               cnt_next = cnt_reg + 16'd1;
            end
         end

         ST_DISPLAY: begin
            oe_n_next = 1'b0;
            if (cnt_reg == on_len - 16'd1) begin
               cnt_next = 16'd0;
               if (plane_reg != PLANE_LAST) begin
                  plane_next        = plane_reg + 3'd1;
                  x_next            = 6'd0;
                  phase_next        = 1'b0;
                  read_address_next = {read_address_reg[6], 6'd0};
                  state_next        = ST_PREFETCH;
               end else begin
                  state_next = ST_WAIT_GEN;
               end
            end else begin
               cnt_next = cnt_reg + 16'd1;
            end
         end

         default: state_next = ST_PRIME;
      endcase
   end

   // State and output registers; reset drops everything back to PRIME with the panel dark.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg        <= ST_PRIME;
         gen_start_reg    <= 1'b0;
         gen_y_reg        <= 5'd0;
         frame_count_reg  <= 10'd0;
         read_address_reg <= 7'd0;
         rgb_reg          <= 6'd0;
         hclk_reg         <= 1'b0;
         lat_reg          <= 1'b0;
         oe_n_reg         <= 1'b1;
         addr_reg         <= 5'd0;
         row_disp_reg     <= 5'd0;
         plane_reg        <= 3'd0;
         x_reg            <= 6'd0;
         phase_reg        <= 1'b0;
         cnt_reg          <= 16'd0;
      end else begin
         state_reg        <= state_next;
         gen_start_reg    <= gen_start_next;
         gen_y_reg        <= gen_y_next;
         frame_count_reg  <= frame_count_next;
         read_address_reg <= read_address_next;
         rgb_reg          <= rgb_next;
         hclk_reg         <= hclk_next;
         lat_reg          <= lat_next;
         oe_n_reg         <= oe_n_next;
         addr_reg         <= addr_next;
         row_disp_reg     <= row_disp_next;
         plane_reg        <= plane_next;
         x_reg            <= x_next;
         phase_reg        <= phase_next;
         cnt_reg          <= cnt_next;
      end
   end

   assign bus.gen_start    = gen_start_reg;
   assign bus.gen_y        = gen_y_reg;
   assign bus.frame_count  = frame_count_reg;
   assign bus.read_address = read_address_reg;
   assign bus.hub75_rgb    = rgb_reg;
   assign bus.hub75_clk    = hclk_reg;
   assign bus.hub75_lat    = lat_reg;
   assign bus.hub75_oe_n   = oe_n_reg;
   assign bus.hub75_addr   = addr_reg;

endmodule

// File: tb/tb_hub75_line_scanner.sv
// Directed bench for hub75_line_scanner (WIDTH=4, COLOR_BITS=2, ON_UNIT=2).
// A small generator model goes idle 5 cycles after each start pulse and a
// two-bank line-buffer model answers reads with one cycle of latency.
module tb_hub75_line_scanner;
   localparam int WIDTH        = 4;
   localparam int COLOR_BITS   = 2;
   localparam int ROWS         = 32;
   localparam int ON_UNIT      = 2;
   localparam int BLANK_CYCLES = 2;
`ifdef HUB75_GHOST_BLANK_EN
   localparam int EXP_GAP = 2;
`else
   localparam int EXP_GAP = 0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        hold_gen = 1'b0;
   logic        model_idle;
   int          gen_cnt;
   logic [47:0] ram_q;
   logic [47:0] mem [0:127];
   logic [5:0]  exp_tab [0:7];   // index plane*4 + x
   int          vectors = 0;
   int          miscompares = 0;

   hub75_line_scanner_if bus ();

   hub75_line_scanner #(
      .WIDTH(WIDTH), .COLOR_BITS(COLOR_BITS), .ROWS(ROWS),
      .ON_UNIT(ON_UNIT), .BLANK_CYCLES(BLANK_CYCLES)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clock = ~clock;

   assign bus.gen_idle  = model_idle & ~hold_gen;
   assign bus.read_data = ram_q;

   // Line-buffer RAM: registered read.
   always @(posedge clock) ram_q <= mem[bus.read_address];

   // Generator model: busy for 5 cycles after a start pulse.
   always @(posedge clock) begin
      if (reset) begin
         model_idle <= 1'b1;
         gen_cnt    <= 0;
      end else if (bus.gen_start) begin
         model_idle <= 1'b0;
         gen_cnt    <= 5;
      end else if (gen_cnt > 1) begin
         gen_cnt <= gen_cnt - 1;
      end else if (gen_cnt == 1) begin
         gen_cnt    <= 0;
         model_idle <= 1'b1;
      end
   end

   // Follow one displayed row until its last plane's lit period ends.
   task automatic scan_row(input logic [4:0] exp_addr, input bit check_px);
      int   plane = 0;
      int   rises = 0;
      int   oe_run = 0;
      int   lat_len = 0;
      int   gap = 0;
      bit   gap_active = 1'b0;
      bit   prev_clk = 1'b0;
      bit   done = 1'b0;
      int   cyc = 0;
      logic [5:0] exp_rgb;
      while (!done && cyc < 400) begin
         @(negedge clock);
         cyc++;
         if (bus.hub75_clk && !prev_clk) begin
            if (check_px) begin
               vectors++;
               if (plane < 2 && rises < 4) begin
                  exp_rgb = exp_tab[plane*4 + rises];
                  if (bus.hub75_rgb !== exp_rgb) begin
                     miscompares++;
                     $display("FAIL rgb row %0d plane %0d x %0d: got %b want %b",
                              exp_addr, plane, rises, bus.hub75_rgb, exp_rgb);
                  end
               end else begin
                  miscompares++;
                  $display("FAIL extra_rise row %0d: plane %0d rise %0d beyond 4", exp_addr, plane, rises);
               end
            end
            vectors++;
            if (bus.read_address[6] !== ~bus.frame_count[0]) begin
               miscompares++;
               $display("FAIL bank row %0d: read bank %b write bank %b", exp_addr,
                        bus.read_address[6], bus.frame_count[0]);
            end
            rises++;
         end
         if (bus.hub75_lat) begin
            lat_len++;
            vectors++;
            if (bus.hub75_addr !== exp_addr) begin
               miscompares++;
               $display("FAIL lat_addr: got %0d want %0d", bus.hub75_addr, exp_addr);
            end
         end else if (lat_len != 0) begin
            vectors++;
            if (lat_len !== 1) begin
               miscompares++;
               $display("FAIL lat_width row %0d: got %0d want 1", exp_addr, lat_len);
            end
            vectors++;
            if (rises !== WIDTH) begin
               miscompares++;
               $display("FAIL rises_before_lat row %0d plane %0d: got %0d want %0d", exp_addr, plane, rises, WIDTH);
            end
            lat_len    = 0;
            gap_active = 1'b1;
            gap        = 0;
         end
         if (gap_active) begin
            if (bus.hub75_oe_n) begin
               gap++;
            end else begin
               vectors++;
               if (gap !== EXP_GAP) begin
                  miscompares++;
                  $display("FAIL blank_gap row %0d: got %0d want %0d", exp_addr, gap, EXP_GAP);
               end
               gap_active = 1'b0;
            end
         end
         if (!bus.hub75_oe_n) begin
            oe_run++;
         end else if (oe_run != 0) begin
            vectors++;
            if (oe_run !== (ON_UNIT << plane)) begin
               miscompares++;
               $display("FAIL oe_len row %0d plane %0d: got %0d want %0d", exp_addr, plane, oe_run, ON_UNIT << plane);
            end
            oe_run = 0;
            plane++;
            rises = 0;
            if (plane == COLOR_BITS) done = 1'b1;
         end
         prev_clk = bus.hub75_clk;
      end
      if (!done) begin
         vectors++;
         miscompares++;
         $display("FAIL row_timeout row %0d: got %0d planes want %0d", exp_addr, plane, COLOR_BITS);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clock);
      vectors++;
      if (bus.hub75_oe_n !== 1'b1) begin miscompares++; $display("FAIL reset_oe_n: got %b want 1", bus.hub75_oe_n); end
      vectors++;
      if (bus.hub75_lat !== 1'b0) begin miscompares++; $display("FAIL reset_lat: got %b want 0", bus.hub75_lat); end
      vectors++;
      if (bus.hub75_clk !== 1'b0) begin miscompares++; $display("FAIL reset_clk: got %b want 0", bus.hub75_clk); end
      vectors++;
      if (bus.frame_count !== 10'd0) begin miscompares++; $display("FAIL reset_frame_count: got %0d want 0", bus.frame_count); end
      vectors++;
      if (bus.gen_start !== 1'b0) begin miscompares++; $display("FAIL reset_gen_start: got %b want 0", bus.gen_start); end
      vectors++;
      if ({bus.hub75_rgb, bus.hub75_addr, bus.read_address, bus.gen_y} !== 23'd0) begin
         miscompares++;
         $display("FAIL reset_zero_outs: rgb %b addr %0d ra %0d y %0d want all 0",
                  bus.hub75_rgb, bus.hub75_addr, bus.read_address, bus.gen_y);
      end
      reset = 1'b0;
      @(negedge clock);
      vectors++;
      if (bus.gen_start !== 1'b1) begin miscompares++; $display("FAIL prime_start: got %b want 1", bus.gen_start); end
      vectors++;
      if (bus.gen_y !== 5'd0) begin miscompares++; $display("FAIL prime_gen_y: got %0d want 0", bus.gen_y); end
   endtask

   task automatic test_first_row();
      scan_row(5'd0, 1'b1);
      vectors++;
      if (bus.frame_count !== 10'd2) begin miscompares++; $display("FAIL row0_frame_count: got %0d want 2", bus.frame_count); end
   endtask

   task automatic test_gen_late();
      int oe_low = 0;
      int clk_hi = 0;
      int starts = 0;
      int waited = 0;
      hold_gen = 1'b1;
      scan_row(5'd1, 1'b1);
      vectors++;
      if (bus.frame_count !== 10'd2) begin miscompares++; $display("FAIL stall_frame_count: got %0d want 2", bus.frame_count); end
      vectors++;
      if (bus.gen_y !== 5'd2) begin miscompares++; $display("FAIL stall_gen_y: got %0d want 2", bus.gen_y); end
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         if (!bus.hub75_oe_n) oe_low++;
         if (bus.hub75_clk)   clk_hi++;
         if (bus.gen_start)   starts++;
      end
      vectors++;
      if (oe_low !== 0) begin miscompares++; $display("FAIL stall_oe_low_cycles: got %0d want 0", oe_low); end
      vectors++;
      if (clk_hi !== 0) begin miscompares++; $display("FAIL stall_clk_pulses: got %0d want 0", clk_hi); end
      vectors++;
      if (starts !== 0) begin miscompares++; $display("FAIL stall_gen_start: got %0d want 0", starts); end
      hold_gen = 1'b0;
      while (!bus.gen_start && waited < 10) begin
         @(negedge clock);
         waited++;
      end
      vectors++;
      if (bus.gen_start !== 1'b1) begin miscompares++; $display("FAIL resume_start: got %b want 1", bus.gen_start); end
      vectors++;
      if (bus.frame_count !== 10'd3) begin miscompares++; $display("FAIL resume_frame_count: got %0d want 3", bus.frame_count); end
      vectors++;
      if (bus.gen_y !== 5'd3) begin miscompares++; $display("FAIL resume_gen_y: got %0d want 3", bus.gen_y); end
   endtask

   task automatic test_reset_mid_shift();
      int waited = 0;
      while (!bus.hub75_clk && waited < 100) begin
         @(negedge clock);
         waited++;
      end
      vectors++;
      if (bus.hub75_clk !== 1'b1) begin miscompares++; $display("FAIL midshift_reach: got clk %b want 1", bus.hub75_clk); end
      reset = 1'b1;
      @(negedge clock);
      vectors++;
      if (bus.hub75_oe_n !== 1'b1 || bus.hub75_clk !== 1'b0 || bus.hub75_lat !== 1'b0) begin
         miscompares++;
         $display("FAIL midshift_pins: oe_n %b clk %b lat %b want 1 0 0", bus.hub75_oe_n, bus.hub75_clk, bus.hub75_lat);
      end
      vectors++;
      if ({bus.hub75_rgb, bus.frame_count, bus.gen_y, bus.read_address, bus.gen_start} !== 29'd0) begin
         miscompares++;
         $display("FAIL midshift_regs: rgb %b fc %0d y %0d ra %0d start %b want all 0",
                  bus.hub75_rgb, bus.frame_count, bus.gen_y, bus.read_address, bus.gen_start);
      end
      reset = 1'b0;
      @(negedge clock);
      vectors++;
      if (bus.gen_start !== 1'b1 || bus.gen_y !== 5'd0) begin
         miscompares++;
         $display("FAIL midshift_restart: start %b y %0d want 1 0", bus.gen_start, bus.gen_y);
      end
      scan_row(5'd0, 1'b1);
   endtask

   task automatic test_row_wrap();
      logic [4:0] exp_y;
      logic [9:0] exp_fc;
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 33; i++) begin
         scan_row(5'(i % ROWS), 1'b0);
         exp_y  = 5'((i + 2) % ROWS);
         exp_fc = 10'(i + 2);
         vectors++;
         if (bus.gen_y !== exp_y) begin miscompares++; $display("FAIL wrap_gen_y row %0d: got %0d want %0d", i, bus.gen_y, exp_y); end
         vectors++;
         if (bus.frame_count !== exp_fc) begin miscompares++; $display("FAIL wrap_frame_count row %0d: got %0d want %0d", i, bus.frame_count, exp_fc); end
         vectors++;
         if (bus.gen_start !== 1'b1) begin miscompares++; $display("FAIL wrap_gen_start row %0d: got %b want 1", i, bus.gen_start); end
      end
   endtask

   initial begin
      for (int a = 0; a < 128; a++) mem[a] = 48'd0;
      for (int b = 0; b < 2; b++) begin
         mem[b*64 + 0] = 48'hFF0000_000000;
         mem[b*64 + 2] = 48'h0100FF_000000;
      end
      exp_tab[0] = 6'b100000; exp_tab[1] = 6'b000000; exp_tab[2] = 6'b101000; exp_tab[3] = 6'b000000;
      exp_tab[4] = 6'b100000; exp_tab[5] = 6'b000000; exp_tab[6] = 6'b001000; exp_tab[7] = 6'b000000;

      test_reset();
      test_first_row();
      test_gen_late();
      test_reset_mid_shift();
      test_row_wrap();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
